// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the MM:SS BCD stopwatch core.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX = 59;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd_pair_t;

  function automatic logic [6:0] bcd_to_bin(bcd_pair_t p);
    return (7'(p.tens) * 7'd10) + 7'(p.units);
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD up/down counter wrapping between 0 and MAX (decimal).
module bcd_pair_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic hold_carry,
  output bcd_t tens,
  output bcd_t units,
  output logic wrap,
  output logic borrow
);

  localparam bcd_t MAX_TENS  = bcd_t'(MAX / 10);
  localparam bcd_t MAX_UNITS = bcd_t'(MAX % 10);

  logic at_max;
  logic at_zero;

  assign at_max  = (tens == MAX_TENS) && (units == MAX_UNITS);
  assign at_zero = (tens == 4'd0) && (units == 4'd0);

  // hold_carry keeps a field-local wrap from rippling into the next field
  assign wrap   = inc && at_max && !hold_carry;
  assign borrow = dec && at_zero && !hold_carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end else if (dec) begin
      if (at_zero) begin
        tens  <= MAX_TENS;
        units <= MAX_UNITS;
      end else if (units == 4'd0) begin
        tens  <= tens - 4'd1;
        units <= 4'd9;
      end else begin
        units <= units - 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch/timer: up/down counting, pause toggle, field adjust.
// The wrap/expiry pulse is named event_pulse because "event" is a reserved word.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX  = 99,
  parameter bit RUN_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       tick_adj,
  input  logic       pause,
  input  logic       adjust,
  input  logic       select,
  input  logic       down,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       running,
  output logic       event_pulse
);

  logic count_en;
  logic adj_en;
  logic sec_inc, sec_dec, sec_wrap, sec_borrow;
  logic min_inc, min_dec, min_wrap, min_borrow;
  logic mins_zero;
  logic at_zero, at_one;
  logic expire, zero_tick, up_wrap;

  assign count_en = !adjust && running && tick;
  assign adj_en   = adjust && tick_adj;

  assign mins_zero = (min1 == 4'd0) && (min0 == 4'd0);
  assign at_zero   = mins_zero && (bcd_to_bin(bcd_pair_t'{tens: sec1, units: sec0}) == 7'd0);
  assign at_one    = mins_zero && (bcd_to_bin(bcd_pair_t'{tens: sec1, units: sec0}) == 7'd1);

  // Down-count stops at 00:00 rather than borrowing to MIN_MAX:59
  assign sec_inc = (count_en && !down) || (adj_en && select);
  assign sec_dec = count_en && down && !at_zero;
  assign min_inc = sec_wrap || (adj_en && !select);
  assign min_dec = sec_borrow;

  assign expire    = count_en && down && at_one;
  assign zero_tick = count_en && down && at_zero;
  assign up_wrap   = sec_wrap && min_wrap;

  bcd_pair_counter #(.MAX(SEC_MAX)) u_sec (
    .clk        (clk),
    .reset      (reset),
    .inc        (sec_inc),
    .dec        (sec_dec),
    .hold_carry (adjust),
    .tens       (sec1),
    .units      (sec0),
    .wrap       (sec_wrap),
    .borrow     (sec_borrow)
  );

  bcd_pair_counter #(.MAX(MIN_MAX)) u_min (
    .clk        (clk),
    .reset      (reset),
    .inc        (min_inc),
    .dec        (min_dec),
    .hold_carry (adjust),
    .tens       (min1),
    .units      (min0),
    .wrap       (min_wrap),
    .borrow     (min_borrow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running     <= RUN_INIT;
      event_pulse <= 1'b0;
    end else begin
      // Expiry clear overrides a coincident pause toggle
      if (expire || zero_tick) begin
        running <= 1'b0;
      end else if (pause) begin
        running <= !running;
      end
      event_pulse <= expire || up_wrap;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: two instances (MIN_MAX 99 and 3) against a time-arithmetic model.
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0, tick_adj = 1'b0, pause = 1'b0;
  logic adjust = 1'b0, select = 1'b0, down = 1'b0;

  logic [3:0] a_min1, a_min0, a_sec1, a_sec0;
  logic       a_running, a_event;
  logic [3:0] b_min1, b_min0, b_sec1, b_sec0;
  logic       b_running, b_event;

  int checks = 0;
  int errors = 0;

  int m_min [2];
  int m_sec [2];
  bit m_run [2];
  bit m_ev  [2];
  int max_min [2] = '{99, 3};

  always #5 clk = ~clk;

  stopwatch_counter #(.MIN_MAX(99), .RUN_INIT(1'b1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .tick_adj(tick_adj), .pause(pause),
    .adjust(adjust), .select(select), .down(down),
    .min1(a_min1), .min0(a_min0), .sec1(a_sec1), .sec0(a_sec0),
    .running(a_running), .event_pulse(a_event)
  );

  stopwatch_counter #(.MIN_MAX(3), .RUN_INIT(1'b1)) dut3 (
    .clk(clk), .reset(reset), .tick(tick), .tick_adj(tick_adj), .pause(pause),
    .adjust(adjust), .select(select), .down(down),
    .min1(b_min1), .min0(b_min0), .sec1(b_sec1), .sec0(b_sec0),
    .running(b_running), .event_pulse(b_event)
  );

  function automatic logic [17:0] a_vec();
    return {a_min1, a_min0, a_sec1, a_sec0, a_running, a_event};
  endfunction

  function automatic logic [17:0] b_vec();
    return {b_min1, b_min0, b_sec1, b_sec0, b_running, b_event};
  endfunction

  function automatic logic [17:0] model_vec(int i);
    return {4'(m_min[i] / 10), 4'(m_min[i] % 10), 4'(m_sec[i] / 10), 4'(m_sec[i] % 10),
            m_run[i], m_ev[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_min[i] = 0; m_sec[i] = 0; m_run[i] = 1'b1; m_ev[i] = 1'b0;
    end
  endtask

  // Works on total elapsed seconds rather than digits
  task automatic model_step(int i, bit t, bit ta, bit p, bit adj, bit sel, bit dn);
    int tot;
    int span;
    bit clr;
    clr = 1'b0;
    m_ev[i] = 1'b0;
    if (adj) begin
      if (ta) begin
        if (sel) m_sec[i] = (m_sec[i] + 1) % 60;
        else     m_min[i] = (m_min[i] + 1) % (max_min[i] + 1);
      end
    end else if (m_run[i] && t) begin
      tot  = m_min[i] * 60 + m_sec[i];
      span = (max_min[i] + 1) * 60;
      if (!dn) begin
        tot = (tot + 1) % span;
        m_ev[i] = (tot == 0);
      end else if (tot == 0) begin
        clr = 1'b1;
      end else begin
        tot = tot - 1;
        if (tot == 0) begin
          m_ev[i] = 1'b1;
          clr = 1'b1;
        end
      end
      m_min[i] = tot / 60;
      m_sec[i] = tot % 60;
    end
    if (clr)    m_run[i] = 1'b0;
    else if (p) m_run[i] = !m_run[i];
  endtask

  task automatic step(bit t, bit ta, bit p, bit adj, bit sel, bit dn);
    tick = t; tick_adj = ta; pause = p;
    adjust = adj; select = sel; down = dn;
    @(posedge clk);
    model_step(0, t, ta, p, adj, sel, dn);
    model_step(1, t, ta, p, adj, sel, dn);
    #1;
    tick = 1'b0; tick_adj = 1'b0; pause = 1'b0;
  endtask

  task automatic do_reset();
    tick = 1'b0; tick_adj = 1'b0; pause = 1'b0;
    adjust = 1'b0; select = 1'b0; down = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (a_vec() !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_a got=%h exp=%h", a_vec(), {16'h0000, 1'b1, 1'b0});
    end
    checks++;
    if (b_vec() !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_b got=%h exp=%h", b_vec(), {16'h0000, 1'b1, 1'b0});
    end
  endtask

  task automatic test_count_up();
    do_reset();
    for (int i = 0; i < 61; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (a_event !== 1'b0) begin
        errors++;
        $display("FAIL up_no_event tick=%0d got=%b exp=0", i, a_event);
      end
    end
    checks++;
    if (a_vec() !== {16'h0101, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL up_61 got=%h exp=%h", a_vec(), {16'h0101, 1'b1, 1'b0});
    end
  endtask

  task automatic test_up_wrap();
    do_reset();
    for (int i = 0; i < 3; i++)  step(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 1, 0, 1, 1, 0);
    checks++;
    if (b_vec() !== {16'h0359, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL preset_0359 got=%h exp=%h", b_vec(), {16'h0359, 1'b1, 1'b0});
    end
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (b_vec() !== {16'h0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_event got=%h exp=%h", b_vec(), {16'h0000, 1'b1, 1'b1});
    end
    checks++;
    if (a_vec() !== {16'h0400, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL no_wrap_99 got=%h exp=%h", a_vec(), {16'h0400, 1'b1, 1'b0});
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (b_vec() !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_event_one_cycle got=%h exp=%h", b_vec(), {16'h0000, 1'b1, 1'b0});
    end
  endtask

  task automatic test_count_down();
    do_reset();
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    checks++;
    if (a_vec() !== {16'h0001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL down_0001 got=%h exp=%h", a_vec(), {16'h0001, 1'b1, 1'b0});
    end
    step(1, 0, 0, 0, 0, 1);
    checks++;
    if (a_vec() !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL down_expire got=%h exp=%h", a_vec(), {16'h0000, 1'b0, 1'b1});
    end
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if (a_vec() !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL down_resume got=%h exp=%h", a_vec(), {16'h0000, 1'b1, 1'b0});
    end
    step(1, 0, 0, 0, 0, 1);
    checks++;
    if (a_vec() !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL down_tick_at_zero got=%h exp=%h", a_vec(), {16'h0000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_pause_tick();
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    checks++;
    if (a_vec() !== {16'h0006, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pause_tick got=%h exp=%h", a_vec(), {16'h0006, 1'b0, 1'b0});
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    checks++;
    if (a_vec() !== {16'h0006, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL paused_hold got=%h exp=%h", a_vec(), {16'h0006, 1'b0, 1'b0});
    end
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (a_vec() !== {16'h0007, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL resume got=%h exp=%h", a_vec(), {16'h0007, 1'b1, 1'b0});
    end
  endtask

  task automatic test_adjust();
    do_reset();
    for (int i = 0; i < 59; i++) step(0, 1, 0, 1, 1, 0);
    checks++;
    if (a_vec() !== {16'h0059, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL adj_0059 got=%h exp=%h", a_vec(), {16'h0059, 1'b1, 1'b0});
    end
    step(0, 1, 0, 1, 1, 0);
    checks++;
    if (a_vec() !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL adj_sec_wrap got=%h exp=%h", a_vec(), {16'h0000, 1'b1, 1'b0});
    end
    for (int i = 0; i < 99; i++) step(1, 1, 0, 1, 0, 0);
    checks++;
    if (a_vec() !== {16'h9900, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL adj_9900 got=%h exp=%h", a_vec(), {16'h9900, 1'b1, 1'b0});
    end
    step(1, 1, 0, 1, 0, 0);
    checks++;
    if (a_vec() !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL adj_min_wrap got=%h exp=%h", a_vec(), {16'h0000, 1'b1, 1'b0});
    end
    checks++;
    if (b_vec() !== model_vec(1)) begin
      errors++;
      $display("FAIL adj_min_wrap_b got=%h exp=%h", b_vec(), model_vec(1));
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    for (int i = 0; i < 12; i++) step(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 33; i++) step(0, 1, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (a_vec() !== {16'h1234, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_1234 got=%h exp=%h", a_vec(), {16'h1234, 1'b1, 1'b0});
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({a_min1, a_min0, a_sec1, a_sec0} !== 16'h0000) begin
      errors++;
      $display("FAIL async_clear got=%h exp=0000", {a_min1, a_min0, a_sec1, a_sec0});
    end
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (a_vec() !== {16'h0001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL after_reset got=%h exp=%h", a_vec(), {16'h0001, 1'b1, 1'b0});
    end
  endtask

  task automatic test_random();
    bit adj, dn, sel;
    do_reset();
    adj = 1'b0; dn = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) adj = !adj;
      if ($urandom_range(0, 59) == 0) dn = !dn;
      sel = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           adj, sel, dn);
      checks++;
      if (a_vec() !== model_vec(0)) begin
        errors++;
        $display("FAIL rand_a cycle=%0d got=%h exp=%h", c, a_vec(), model_vec(0));
      end
      checks++;
      if (b_vec() !== model_vec(1)) begin
        errors++;
        $display("FAIL rand_b cycle=%0d got=%h exp=%h", c, b_vec(), model_vec(1));
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_count_up();
    test_up_wrap();
    test_count_down();
    test_pause_tick();
    test_adjust();
    test_reset_mid_count();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
